// File: rtl/paddle_move_controller.sv
// Paddle motion sequencer: move-tick prescaler, player/auto arbitration,
// single-cycle step strobes toward the paddle position datapath.
module paddle_move_controller #(
  parameter int TICK_DIV   = 50000,
  parameter int IDLE_TICKS = 2000,
  parameter int DEADBAND   = 4,
  parameter int ROW_W      = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             game_active,
  input  logic             player_up,
  input  logic             player_down,
  input  logic [ROW_W-1:0] ball_row,
  input  logic [ROW_W-1:0] paddle_row,
  output logic             move_tick,
  output logic             step_up,
  output logic             step_down,
  output logic             ai_active
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(IDLE_TICKS + 1);
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [IW-1:0]    IDLE_LAST = IW'(IDLE_TICKS - 1);
  localparam logic [IW-1:0]    IDLE_MAX  = IW'(IDLE_TICKS);
  localparam logic [ROW_W:0]   DB        = (ROW_W+1)'(DEADBAND);

  typedef enum logic [1:0] {S_IDLE, S_PLAYER, S_AUTO} state_t;

  state_t          r_state, w_state_nxt;
  logic [TW-1:0]   r_tick_cnt;
  logic            r_move_tick;
  logic [IW-1:0]   r_idle_cnt, w_idle_nxt;
  logic            r_step_up, r_step_dn, w_up_nxt, w_dn_nxt;
  logic            r_ai_active;

  logic            w_activity, w_plr_up, w_plr_dn;
  logic [ROW_W:0]  w_ball_x, w_pad_x;
  logic            w_auto_up, w_auto_dn;

  assign w_activity = player_up | player_down;
  assign w_plr_up   = player_up & ~player_down;
  assign w_plr_dn   = player_down & ~player_up;

  // One extra bit keeps row + DEADBAND from wrapping at the top of the field.
  assign w_ball_x  = {1'b0, ball_row};
  assign w_pad_x   = {1'b0, paddle_row};
  assign w_auto_up = (w_ball_x + DB) < w_pad_x;
  assign w_auto_dn = w_ball_x > (w_pad_x + DB);

  // Free-running prescaler; tick pulse is registered off the terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt  <= '0;
      r_move_tick <= 1'b0;
    end else begin
      r_move_tick <= (r_tick_cnt == TICK_LAST);
      r_tick_cnt  <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
    end
  end

  // Control state, idle counter and registered strobes / ai flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idle_cnt  <= '0;
      r_step_up   <= 1'b0;
      r_step_dn   <= 1'b0;
      r_ai_active <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idle_cnt  <= w_idle_nxt;
      r_step_up   <= w_up_nxt;
      r_step_dn   <= w_dn_nxt;
      r_ai_active <= (w_state_nxt == S_AUTO);
    end
  end

  // Per-tick arbitration. The tick that leaves IDLE is handled as an
  // ordinary player tick, so it counts toward the idle takeover too.
  always_comb begin
    w_state_nxt = r_state;
    w_idle_nxt  = r_idle_cnt;
    w_up_nxt    = 1'b0;
    w_dn_nxt    = 1'b0;
    if (r_move_tick) begin
      if (!game_active) begin
        w_state_nxt = S_IDLE;
        w_idle_nxt  = '0;
      end else if (r_state == S_AUTO && !w_activity) begin
        w_up_nxt = w_auto_up;
        w_dn_nxt = w_auto_dn;
      end else if (w_activity) begin
        // Player always wins, including against the auto controller.
        w_state_nxt = S_PLAYER;
        w_idle_nxt  = '0;
        w_up_nxt    = w_plr_up;
        w_dn_nxt    = w_plr_dn;
      end else if (r_idle_cnt >= IDLE_LAST) begin
        w_state_nxt = S_AUTO;
        w_idle_nxt  = IDLE_MAX;
      end else begin
        w_state_nxt = S_PLAYER;
        w_idle_nxt  = r_idle_cnt + 1'b1;
      end
    end
  end

  assign move_tick = r_move_tick;
  assign step_up   = r_step_up;
  assign step_down = r_step_dn;
  assign ai_active = r_ai_active;

endmodule

// File: tb/tb_paddle_move_controller.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a behavioural model.
module tb_paddle_move_controller;

  localparam int TICK_DIV   = 4;
  localparam int IDLE_TICKS = 3;
  localparam int DEADBAND   = 2;
  localparam int ROW_W      = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic game_active = 1'b0, player_up = 1'b0, player_down = 1'b0;
  logic [ROW_W-1:0] ball_row = '0, paddle_row = '0;
  logic move_tick, step_up, step_down, ai_active;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  paddle_move_controller #(
    .TICK_DIV(TICK_DIV), .IDLE_TICKS(IDLE_TICKS), .DEADBAND(DEADBAND), .ROW_W(ROW_W)
  ) dut (
    .clk(clk), .rst(rst), .game_active(game_active),
    .player_up(player_up), .player_down(player_down),
    .ball_row(ball_row), .paddle_row(paddle_row),
    .move_tick(move_tick), .step_up(step_up), .step_down(step_down),
    .ai_active(ai_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: cycles since reset, a mode (0 idle, 1 player, 2 auto)
  // and a count of consecutive idle player ticks.
  int  m_cyc = 0, m_mode = 0, m_idle = 0;
  bit  e_tick = 0, e_up = 0, e_dn = 0, e_ai = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_cyc = 0; m_mode = 0; m_idle = 0;
      e_tick = 0; e_up = 0; e_dn = 0; e_ai = 0;
    end else begin
      bit act;
      int b, p;
      e_up = 0; e_dn = 0;
      act = player_up | player_down;
      b = int'(ball_row); p = int'(paddle_row);
      if (e_tick) begin
        if (!game_active) begin
          m_mode = 0; m_idle = 0;
        end else if (m_mode == 2 && !act) begin
          e_up = (b + DEADBAND < p);
          e_dn = (b > p + DEADBAND);
        end else if (act) begin
          m_mode = 1; m_idle = 0;
          e_up = player_up && !player_down;
          e_dn = player_down && !player_up;
        end else begin
          m_idle = m_idle + 1;
          m_mode = (m_idle >= IDLE_TICKS) ? 2 : 1;
        end
      end
      m_cyc++;
      e_tick = (m_cyc % TICK_DIV == 0);
      e_ai   = (m_mode == 2);
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("move_tick", int'(move_tick), int'(e_tick));
      chk("step_up",   int'(step_up),   int'(e_up));
      chk("step_down", int'(step_down), int'(e_dn));
      chk("ai_active", int'(ai_active), int'(e_ai));
      chk("strobe_excl", int'(step_up & step_down), 0);
    end
  end

  // Count negedges until move_tick is seen (bounded).
  task automatic cycles_to_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!move_tick && n < 4 * TICK_DIV);
  endtask

  // Let the pending/next tick happen, return at the strobe cycle.
  task automatic do_tick();
    int k = 0;
    while (!move_tick && k < 4 * TICK_DIV) begin
      @(negedge clk);
      k++;
    end
    if (!move_tick) chk("tick_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic set_btn(input bit u, input bit d);
    player_up = u; player_down = d;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_tick", int'(move_tick), 0);
    chk("reset_ai",   int'(ai_active), 0);
    rst = 1'b0;

    // 1: tick period and mid-operation reset
    cycles_to_tick(n); chk("first_tick_lat", n, 4);
    cycles_to_tick(n); chk("tick_period", n, 4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_tick", int'(move_tick), 0);
    chk("rst_mid_up", int'(step_up | step_down), 0);
    rst = 1'b0;
    cycles_to_tick(n); chk("tick_after_rst", n, 4);

    // 2: player requests
    game_active = 1'b1; set_btn(1, 0);
    do_tick(); chk("plr_up", int'(step_up), 1); chk("plr_up_dn", int'(step_down), 0);
    @(negedge clk); chk("up_one_cycle", int'(step_up), 0);
    set_btn(1, 1);
    do_tick(); chk("plr_both", int'(step_up | step_down), 0);
    set_btn(0, 1);
    do_tick(); chk("plr_down", int'(step_down), 1); chk("plr_down_up", int'(step_up), 0);

    // 3: idle takeover
    set_btn(0, 0);
    do_tick(); chk("idle1", int'(step_up | step_down | ai_active), 0);
    do_tick(); chk("idle2", int'(step_up | step_down | ai_active), 0);
    do_tick(); chk("idle3_nostep", int'(step_up | step_down), 0);
    chk("idle3_ai", int'(ai_active), 1);

    // 4: auto deadband
    paddle_row = 12'd300;
    ball_row = 12'd297; do_tick(); chk("auto_297_up", int'(step_up), 1);
    ball_row = 12'd298; do_tick(); chk("auto_298", int'(step_up | step_down), 0);
    ball_row = 12'd302; do_tick(); chk("auto_302", int'(step_up | step_down), 0);
    ball_row = 12'd303; do_tick(); chk("auto_303_dn", int'(step_down), 1);
    chk("auto_303_up", int'(step_up), 0);
    ball_row = 12'd4095; paddle_row = 12'd4094;
    do_tick(); chk("auto_ovf", int'(step_up | step_down), 0);
    chk("auto_still_ai", int'(ai_active), 1);

    // 5: player overrides auto
    paddle_row = 12'd300; ball_row = 12'd400; set_btn(1, 0);
    do_tick(); chk("override_up", int'(step_up), 1); chk("override_ai", int'(ai_active), 0);
    set_btn(0, 0);
    do_tick(); chk("re_idle1_ai", int'(ai_active), 0);
    do_tick(); chk("re_idle2_ai", int'(ai_active), 0);
    do_tick(); chk("re_idle3_ai", int'(ai_active), 1);
    do_tick(); chk("auto_400_dn", int'(step_down), 1);

    // 6: game_active drop / restore
    game_active = 1'b0;
    do_tick(); chk("drop_step", int'(step_up | step_down), 0); chk("drop_ai", int'(ai_active), 0);
    game_active = 1'b1; set_btn(0, 1);
    do_tick(); chk("restore_dn", int'(step_down), 1); chk("restore_ai", int'(ai_active), 0);

    // Randomized phase, checked by the compare process against the model
    for (int i = 0; i < 4000; i++) begin
      game_active = ($urandom_range(0, 15) != 0);
      player_up   = ($urandom_range(0, 9) == 0);
      player_down = ($urandom_range(0, 9) == 0);
      paddle_row  = ROW_W'($urandom);
      if ($urandom_range(0, 3) == 0)
        ball_row = ROW_W'($urandom);
      else
        ball_row = paddle_row + ROW_W'($urandom_range(0, 12)) - ROW_W'(6);
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
